spi_sequencer: RTL
==================

# spi_sequencer

Master-side SPI transfer controller that sequences the 8-bit `shift_register` datapath for one full-duplex SPI mode-0 byte transfer. On a start request it parallel-loads the transmit byte, then drives chip select and SCLK. It captures MISO and issues one shift command per bit. At the end it enables the shift register's parallel output for the received byte. It sits between the host-facing command logic and the shift register / SPI pads.

## Interface
Parameters:
- `CLK_DIV`, default 4: `i_clk` cycles per SCLK half-period (D); legal range 1..255.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  transfer request; sampled only in IDLE.
- `i_msb_first`  in  1  latched in LOAD.
  - 1 = MSB first (shift-left commands).
  - 0 = LSB first (shift-right commands).
- `i_miso`  in  1  SPI MISO pad.
- `o_busy`  out  1  high from LOAD through TRAIL.
- `o_done`  out  1  one-cycle pulse in DONE.
- `o_cs_n`  out  1  SPI chip select, active-low.
- `o_sclk`  out  1  SPI clock, idle low (CPOL=0, CPHA=0).
- `o_sr_mode`  out  2  to shift register `i_mode`: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `o_sr_oe_n`  out  1  to shift register `i_output_enable_n`.
- `o_sr_serial`  out  1  to shift register `i_serial`; registered MISO sample.

MOSI is the shift register's `o_serial`, wired at top level and not routed through this block.

## Operation
States: IDLE, LOAD, LEAD, HIGH, LOW, TRAIL, DONE.
- **IDLE:** `o_cs_n`=1, `o_sclk`=0, `o_sr_mode`=00. On `i_start`=1, go to LOAD.
- **LOAD:** one cycle. `o_sr_mode`=11, `o_sr_oe_n`=1, latch `i_msb_first`, clear bit counter. Go to LEAD.
- **LEAD:** `o_cs_n`=0, `o_sclk`=0 for D cycles, giving MOSI setup time. Go to HIGH.
- **HIGH:** `o_sclk`=1 for D cycles. On the `i_clk` edge entering HIGH, the MISO capture register loads `i_miso`. After D cycles, go to LOW if bit counter < 7, else go to TRAIL.
- **LOW:** `o_sclk`=0 for D cycles.
  - First cycle only: `o_sr_mode` = 10 if MSB-first, else 01. Remaining cycles: 00.
  - Bit counter increments on exit. Go to HIGH.
- **TRAIL:** same as LOW (shift pulse in first cycle, `o_cs_n`=0 for D cycles). This shift stores the 8th bit. Go to DONE.
- **DONE:** one cycle. `o_cs_n`=1, `o_done`=1, `o_busy`=0, `o_sr_oe_n`=0. Go to IDLE.
- `o_sr_oe_n` stays 0 from DONE until the next LOAD.
- `i_start` is ignored outside IDLE.
- `o_sr_serial` equals the capture register at all times.
- Exactly 8 SCLK rising edges and exactly 8 shift pulses occur per transfer.

Reset (any state, including mid-transfer): next cycle the block is in IDLE.
- `o_cs_n`=1, `o_sclk`=0, `o_sr_mode`=00, `o_sr_oe_n`=1, `o_busy`=0, `o_done`=0, `o_sr_serial`=0.
- Bit counter and divider count are 0.
- No `o_done` pulse for an aborted transfer. The shift register contents are not touched.

## Timing
- All outputs are registered.
- Divider counts D-1 down to 0 within each timed state; the state advances when it reaches 0.
- With `i_start` sampled high at cycle t:
  - LOAD at t+1.
  - LEAD at t+2 .. t+1+D.
  - First SCLK rise at t+2+D.
  - SCLK period is 2D; TRAIL ends at t+1+17D.
  - DONE at t+2+17D (D=4: t+70).
- Minimum start-to-start spacing is 17D+3 cycles (DONE, then one IDLE cycle).
- CS low for 17D cycles. SCLK high phase is exactly D cycles.

## Structure
- Package `spi_pkg`:
  - `sr_mode_t` enum: SR_HOLD=2'b00, SR_SHR=2'b01, SR_SHL=2'b10, SR_LOAD=2'b11.
  - `seq_state_t` enum.
  - Constant `SPI_WORD_BITS`=8.
- Sub-module `spi_clk_divider`: loadable down-counter of width $clog2(CLK_DIV+1). Takes the reload value and produces a terminal-count output.
- Top file holds the FSM, bit counter and MISO capture register.

## Test plan
- Reset: hold `i_rst` 3 cycles → `o_cs_n`=1, `o_sclk`=0, `o_sr_mode`=00, `o_sr_oe_n`=1, `o_busy`=0, `o_done`=0.
- CLK_DIV=4, `i_msb_first`=1, slave model drives 0xA5, real `shift_register` preloaded 0x3C:
  - `o_sr_mode`=11 at t+1, `o_cs_n` falls at t+2.
  - Eight 10-pulses; MOSI bits read 0,0,1,1,1,1,0,0.
  - `o_done` at t+70; parallel output reads 0xA5.
- `i_msb_first`=0, slave 0x81: eight 01-pulses, received byte 0x81, LSB of TX byte appears first on MOSI.
- `i_start` held high continuously: start pulses during busy are ignored; second LOAD at t+72; two `o_done` pulses 71 cycles apart.
- `i_rst` for one cycle after the 4th SCLK rise → next cycle all outputs at reset values; no `o_done`; subsequent transfer completes normally.
- CLK_DIV=1: SCLK period 2 cycles, 8 rises, `o_done` at t+19.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer sequencer.
package spi_pkg;

    localparam int SPI_WORD_BITS = 8;

    // Command encoding understood by the 8-bit shift register's mode input.
    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_SHR  = 2'b01,
        SR_SHL  = 2'b10,
        SR_LOAD = 2'b11
    } sr_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/spi_clk_divider.sv
// Loadable down-counter that times each SCLK half-period phase.
module spi_clk_divider #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_reload,
    output logic         o_tc
);

    logic [W-1:0] count;

    // Reload on phase entry, then count down and park at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_reload;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_tc = (count == '0);

endmodule

// File: rtl/spi_sequencer.sv
// SPI mode-0 master sequencer: drives CS/SCLK and commands the shift register
// through one full-duplex byte transfer.
module spi_sequencer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_msb_first,
    input  logic       i_miso,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_cs_n,
    output logic       o_sclk,
    output logic [1:0] o_sr_mode,
    output logic       o_sr_oe_n,
    output logic       o_sr_serial
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(SPI_WORD_BITS);
    localparam logic [DIV_W-1:0] RELOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_WORD_BITS - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic             msb_q;
    logic             miso_q;
    logic             tc;
    logic             entering;
    logic             cs_n_d, sclk_d, busy_d, done_d, oe_n_d;
    sr_mode_t         mode_d;

    // The divider restarts on every state change, so each timed phase lasts D cycles.
    spi_clk_divider #(.W(DIV_W)) u_div (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (entering),
        .i_reload (RELOAD),
        .o_tc     (tc)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, plus the output values that go with the state being entered
    // so the registered outputs line up with the state itself.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_LEAD;
            ST_LEAD:  if (tc) state_d = ST_HIGH;
            ST_HIGH:  if (tc) state_d = (bit_cnt < LAST_BIT) ? ST_LOW : ST_TRAIL;
            ST_LOW:   if (tc) state_d = ST_HIGH;
            ST_TRAIL: if (tc) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        entering = (state_d != state_q);
        cs_n_d   = 1'b1;
        sclk_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        mode_d   = SR_HOLD;
        oe_n_d   = o_sr_oe_n;
        unique case (state_d)
            ST_LOAD: begin
                busy_d = 1'b1;
                mode_d = SR_LOAD;
                oe_n_d = 1'b1;
            end
            ST_LEAD: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
            end
            ST_HIGH: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
                sclk_d = 1'b1;
            end
            ST_LOW, ST_TRAIL: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
                // Single shift pulse on the first cycle after the falling edge.
                if (entering) mode_d = msb_q ? SR_SHL : SR_SHR;
            end
            ST_DONE: begin
                done_d = 1'b1;
                oe_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cs_n    <= 1'b1;
            o_sclk    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_sr_mode <= SR_HOLD;
            o_sr_oe_n <= 1'b1;
        end else begin
            o_cs_n    <= cs_n_d;
            o_sclk    <= sclk_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
            o_sr_mode <= mode_d;
            o_sr_oe_n <= oe_n_d;
        end
    end

    // Bit counter, bit-order latch and MISO capture on the SCLK rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt <= '0;
            msb_q   <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                bit_cnt <= '0;
                msb_q   <= i_msb_first;
            end else if (state_q == ST_LOW && tc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_d == ST_HIGH && state_q != ST_HIGH) miso_q <= i_miso;
        end
    end

    assign o_sr_serial = miso_q;

endmodule
